// File: rtl/amba_bfm_pkg.sv
// amba_bfm_pkg
//   Shared AMBA bus-functional-model definitions: AHB-Lite transfer codes,
//   fixed size/burst encodings and the APB-to-AHB bridge state encoding.
package amba_bfm_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  localparam logic [2:0] HSIZE_WORD    = 3'b010;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_DONE = 2'd3
  } bridge_state_e;

endpackage : amba_bfm_pkg

// File: rtl/bfm_apbtoahb.sv
// bfm_apbtoahb
//   APB3 completer to AHB-Lite manager bridge. Every APB transfer becomes one
//   single word-sized AHB-Lite transfer; AHB read data and error status are
//   returned on the APB side. At most one AHB transfer is outstanding.
//
// Ports
//   HCLK, HRESETN             shared clock, asynchronous active-low reset
//   PSEL/PENABLE/PWRITE       APB control
//   PADDR, PWDATA             APB address / write data (PADDR used as HADDR)
//   PRDATA/PREADY/PSLVERR     APB response (registered)
//   HADDR/HTRANS/HWRITE       AHB address phase (registered)
//   HSIZE/HBURST/HMASTLOCK/HPROT  constant AHB attributes
//   HWDATA                    AHB write data (registered)
//   HRDATA/HREADY/HRESP       AHB response inputs
//
// All outputs come straight from flops; TPD is the nominal clock-to-output
// delay of the BFM and is a simulation-only annotation, not modelled here.
module bfm_apbtoahb
  import amba_bfm_pkg::*;
#(
  parameter int         TPD       = 1,
  parameter logic [3:0] HPROT_VAL = 4'b0011
) (
  input  logic        HCLK,
  input  logic        HRESETN,
  // APB completer side
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [31:0] PADDR,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR,
  // AHB-Lite manager side
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [2:0]  HBURST,
  output logic        HMASTLOCK,
  output logic [3:0]  HPROT,
  output logic [31:0] HWDATA,
  input  logic [31:0] HRDATA,
  input  logic        HREADY,
  input  logic        HRESP
);

  if (TPD < 0) begin : g_tpd_check
    $error("bfm_apbtoahb: TPD must be non-negative");
  end

  bridge_state_e state;
  htrans_e       htrans_q;
  logic [31:0]   wdata_q;   // write data latched in the APB setup phase

  // Constant transfer attributes are plain wires so they are valid in reset.
  assign HSIZE     = HSIZE_WORD;
  assign HBURST    = HBURST_SINGLE;
  assign HMASTLOCK = 1'b0;
  assign HPROT     = HPROT_VAL;
  assign HTRANS    = htrans_q;

  // NOTE: every register here, including the data-capture registers, is in
  // the reset list so a mid-transfer reset drops the bus to a clean idle.
  // NOTE: sequential state uses non-blocking assignments only, so all
  // branches see pre-edge values regardless of statement order.
  always_ff @(posedge HCLK or negedge HRESETN) begin
    if (!HRESETN) begin
      state    <= ST_IDLE;
      htrans_q <= HTRANS_IDLE;
      HADDR    <= 32'h0;
      HWRITE   <= 1'b0;
      HWDATA   <= 32'h0;
      wdata_q  <= 32'h0;
      PRDATA   <= 32'h0;
      PREADY   <= 1'b0;
      PSLVERR  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          // Only the setup phase starts a transfer; a stray access phase
          // (PSEL=1, PENABLE=1) seen here is ignored.
          if (PSEL && !PENABLE) begin
            HADDR    <= PADDR;
            HWRITE   <= PWRITE;
            wdata_q  <= PWDATA;
            htrans_q <= HTRANS_NONSEQ;
            state    <= ST_ADDR;
          end
        end

        ST_ADDR: begin
          // HRESP is meaningless while our address phase is pending.
          if (HREADY) begin
            htrans_q <= HTRANS_IDLE;
            HWDATA   <= wdata_q;
            state    <= ST_DATA;
          end
        end

        ST_DATA: begin
          // The first cycle of a two-cycle error (HRESP=1, HREADY=0) is just
          // another wait; the response is taken on the HREADY=1 cycle.
          if (HREADY) begin
            if (!HWRITE) begin
              PRDATA <= HRDATA;
            end
            PSLVERR <= HRESP;
            PREADY  <= 1'b1;
            state   <= ST_DONE;
          end
        end

        ST_DONE: begin
          // APB side is not rechecked: the completion pulse is one cycle.
          PREADY  <= 1'b0;
          PSLVERR <= 1'b0;
          state   <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule : bfm_apbtoahb

// File: tb/tb_bfm_apbtoahb.sv
// tb_bfm_apbtoahb
//   Directed self-checking bench for bfm_apbtoahb. The bench plays both the
//   APB requester and the AHB responder, cycle by cycle, and compares DUT
//   outputs against hand-derived expectations.
module tb_bfm_apbtoahb;

  logic        HCLK = 1'b0;
  logic        HRESETN;
  logic        PSEL, PENABLE, PWRITE;
  logic [31:0] PADDR, PWDATA, PRDATA;
  logic        PREADY, PSLVERR;
  logic [31:0] HADDR, HWDATA, HRDATA;
  logic [1:0]  HTRANS;
  logic        HWRITE, HMASTLOCK, HREADY, HRESP;
  logic [2:0]  HSIZE, HBURST;
  logic [3:0]  HPROT;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] exp_prdata = 32'h0;

  always #5 HCLK = ~HCLK;

  bfm_apbtoahb #(.TPD(1), .HPROT_VAL(4'b0011)) dut (
    .HCLK(HCLK), .HRESETN(HRESETN),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE),
    .HSIZE(HSIZE), .HBURST(HBURST), .HMASTLOCK(HMASTLOCK), .HPROT(HPROT),
    .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 ns after it.
  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  // One complete APB transfer against a scripted AHB responder.
  //   aw/dw : HREADY=0 cycles in the AHB address / data phase
  //   err   : two-cycle error response (needs dw >= 1)
  //   b2b   : leave PSEL asserted so the next setup follows immediately
  task automatic xfer(input logic wr, input logic [31:0] addr,
                      input logic [31:0] wdata, input int aw, input int dw,
                      input logic err, input logic [31:0] rd, input logic b2b,
                      input string nm);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wdata;
    HREADY = 1'b1; HRESP = 1'b0;
    step();                                   // E0: setup sampled
    PENABLE = 1'b1;
    check({nm, ".htrans_nonseq"}, HTRANS, 32'h2);
    check({nm, ".haddr"},         HADDR,  addr);
    check({nm, ".hwrite"},        HWRITE, wr);
    for (int i = 0; i < aw; i++) begin
      HREADY = 1'b0;
      HRESP  = 1'b1;                          // must be ignored in ADDR
      step();
      check({nm, ".addr_hold_htrans"}, HTRANS, 32'h2);
      check({nm, ".addr_hold_haddr"},  HADDR,  addr);
      check({nm, ".addr_hold_hwrite"}, HWRITE, wr);
    end
    HREADY = 1'b1; HRESP = 1'b0;
    step();                                   // data phase begins
    check({nm, ".htrans_idle"}, HTRANS, 32'h0);
    check({nm, ".pready_early"}, PREADY, 32'h0);
    if (wr) check({nm, ".hwdata"}, HWDATA, wdata);
    for (int i = 0; i < dw; i++) begin
      HREADY = 1'b0;
      HRESP  = err && (i == dw - 1);
      HRDATA = 32'hFFFF_FFFF;
      step();
      check({nm, ".pready_wait"}, PREADY, 32'h0);
    end
    HREADY = 1'b1; HRESP = err; HRDATA = rd;
    step();                                   // DONE
    if (!wr) exp_prdata = rd;
    check({nm, ".pready"},  PREADY,  32'h1);
    check({nm, ".pslverr"}, PSLVERR, err);
    check({nm, ".prdata"},  PRDATA,  exp_prdata);
    if (!b2b) begin
      PSEL = 1'b0; PENABLE = 1'b0;
    end
    HRESP = 1'b0; HRDATA = 32'h0;
    step();                                   // APB completes
    check({nm, ".pready_pulse"},  PREADY,  32'h0);
    check({nm, ".pslverr_clear"}, PSLVERR, 32'h0);
    check({nm, ".no_overlap"},    HTRANS,  32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    HRESETN = 1'b0;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    PADDR = 32'h0; PWDATA = 32'h0;
    HRDATA = 32'h0; HREADY = 1'b1; HRESP = 1'b0;
    #12;
    // Reset state and constants valid during reset.
    check("rst.htrans",    HTRANS,    32'h0);
    check("rst.haddr",     HADDR,     32'h0);
    check("rst.hwrite",    HWRITE,    32'h0);
    check("rst.hwdata",    HWDATA,    32'h0);
    check("rst.prdata",    PRDATA,    32'h0);
    check("rst.pready",    PREADY,    32'h0);
    check("rst.pslverr",   PSLVERR,   32'h0);
    check("rst.hsize",     HSIZE,     32'h2);
    check("rst.hburst",    HBURST,    32'h0);
    check("rst.hmastlock", HMASTLOCK, 32'h0);
    check("rst.hprot",     HPROT,     32'h3);
    @(negedge HCLK);
    HRESETN = 1'b1;
    step();

    // Zero-wait write.
    xfer(1'b1, 32'h0000_0010, 32'hA5A5_1234, 0, 0, 1'b0, 32'h0, 1'b0, "wr0");
    // Read with two data-phase wait states.
    xfer(1'b0, 32'h0000_0040, 32'h0, 0, 2, 1'b0, 32'hDEAD_BEEF, 1'b0, "rd2w");
    // Two-cycle error on a write; PRDATA must stay at the last read value.
    xfer(1'b1, 32'h0000_0080, 32'h1111_2222, 0, 1, 1'b1, 32'h0, 1'b0, "wrerr");
    // Failing read returns the data seen in the error cycle.
    xfer(1'b0, 32'h0000_00C0, 32'h0, 0, 1, 1'b1, 32'h0BAD_0BAD, 1'b0, "rderr");
    // Three address-phase wait states, HRESP noise ignored.
    xfer(1'b1, 32'h0000_0100, 32'h5555_AAAA, 3, 0, 1'b0, 32'h0, 1'b0, "aw3");
    // Back-to-back read then write, no APB idle.
    xfer(1'b0, 32'h0000_0200, 32'h0, 0, 0, 1'b0, 32'h1234_5678, 1'b1, "b2b_rd");
    xfer(1'b1, 32'h0000_0204, 32'hCAFE_F00D, 0, 0, 1'b0, 32'h0, 1'b0, "b2b_wr");

    // Stray access phase while idle is ignored.
    PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b1; PADDR = 32'h0000_0300;
    step();
    step();
    check("stray.htrans", HTRANS, 32'h0);
    check("stray.haddr",  HADDR,  32'h0000_0204);
    PSEL = 1'b0; PENABLE = 1'b0;
    step();

    // Reset while in the data phase of a read.
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 32'h0000_0400;
    HREADY = 1'b1;
    step();
    PENABLE = 1'b1;
    step();
    HREADY = 1'b0;
    step();
    check("rstmid.in_data", HTRANS, 32'h0);
    HRESETN = 1'b0;
    #1;
    check("rstmid.htrans", HTRANS, 32'h0);
    check("rstmid.pready", PREADY, 32'h0);
    check("rstmid.prdata", PRDATA, 32'h0);
    check("rstmid.haddr",  HADDR,  32'h0);
    exp_prdata = 32'h0;
    PSEL = 1'b0; PENABLE = 1'b0; HREADY = 1'b1;
    @(negedge HCLK);
    HRESETN = 1'b1;
    step();
    xfer(1'b0, 32'h0000_0500, 32'h0, 0, 1, 1'b0, 32'h7777_8888, 1'b0, "post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_bfm_apbtoahb
